ucsbece154b_perfmon: RTL and testbench

Synthesizable performance monitor for the dual-issue RISC-V pipeline. It sits beside the datapath inside `ucsbece154b_top` and observes both fetch lanes and both decode lanes. It counts elapsed cycles and useful decoded instructions, and detects program completion: both lanes re-fetching a NOP at an unchanged PC. Counters and status are exposed through a registered request/acknowledge read port for a debug host or bench.

---
 rtl/ucsbece154b_perfmon_if.sv | 30 +++
 rtl/ucsbece154b_perfmon.sv | 167 ++++++++++++++++
 tb/tb_ucsbece154b_perfmon.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ucsbece154b_perfmon_if.sv
// Pipeline observation and debug read bus for ucsbece154b_perfmon.
// master: pipeline/debug host side, slave: the performance monitor.
interface ucsbece154b_perfmon_if;
   logic [31:0] PCF_i;
   logic [31:0] InstrF_i;
   logic [31:0] PCF2_i;
   logic [31:0] InstrF2_i;
   logic [31:0] InstrD_i;
   logic [31:0] InstrD2_i;
   logic        StallD_i;
   logic        clear_i;
   logic        rd_req_i;
   logic [2:0]  rd_addr_i;
   logic        rd_ack_o;
   logic [31:0] rd_data_o;
   logic        halted_o;
   logic        timeout_o;

   modport master (
      output PCF_i, InstrF_i, PCF2_i, InstrF2_i, InstrD_i, InstrD2_i,
             StallD_i, clear_i, rd_req_i, rd_addr_i,
      input  rd_ack_o, rd_data_o, halted_o, timeout_o
   );

   modport slave (
      input  PCF_i, InstrF_i, PCF2_i, InstrF2_i, InstrD_i, InstrD2_i,
             StallD_i, clear_i, rd_req_i, rd_addr_i,
      output rd_ack_o, rd_data_o, halted_o, timeout_o
   );
endinterface

// File: rtl/ucsbece154b_perfmon.sv
// Performance monitor for the dual-issue pipeline: saturating cycle and
// useful-instruction counters, halt detection (both lanes re-fetching NOP at
// an unchanged PC), cycle-budget timeout and a 1-cycle registered read port.
// Optional macro PERFMON_LANE_STATS_EN adds dual-issue and stall counters
// at read addresses 4 and 5.
module ucsbece154b_perfmon #(
   parameter int          CNT_W      = 32,
   parameter logic [31:0] NOP        = 32'h00000013,
   parameter int          MAX_CYCLES = 200
) (
   input logic                   clk,
   input logic                   reset,
   ucsbece154b_perfmon_if.slave  bus
);

   typedef enum logic [1:0] {RUN, HALTED, TIMEOUT} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Timeout compare is done wider than the counter so a narrow counter
   // never aliases the budget (e.g. 200 mod 16).
   typedef logic [CNT_W+31:0] wide_t;
   localparam wide_t MAX_W = wide_t'(MAX_CYCLES);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cyc_cnt_reg, ins_cnt_reg;
   logic [CNT_W-1:0]  cyc_cnt_next, ins_cnt_next;
   logic [31:0]       prev_pc1_reg, prev_pc2_reg, halt_pc_reg;
   logic              prev_vld_reg;
   logic              rd_ack_reg;
   logic [31:0]       rd_data_reg, rd_data_next;
   logic [31:0]       instr_d [2];
   logic [1:0]        lane_vld;
   logic [1:0]        ins_inc;
   logic              halt_det, cnt_en, timeout_hit;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0] inc);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
      return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
   endfunction

   assign instr_d[0] = bus.InstrD_i;
   assign instr_d[1] = bus.InstrD2_i;

   // A decode lane is useful when it holds a real instruction and is not stalled.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         assign lane_vld[gi] = (instr_d[gi] != 32'd0) && (instr_d[gi] != NOP) &&
                               !bus.StallD_i;
      end
   endgenerate

   assign ins_inc      = {1'b0, lane_vld[0]} + {1'b0, lane_vld[1]};
   assign halt_det     = prev_vld_reg &&
                         (bus.PCF_i  == prev_pc1_reg) && (bus.InstrF_i  == NOP) &&
                         (bus.PCF2_i == prev_pc2_reg) && (bus.InstrF2_i == NOP);
   assign cnt_en       = (state_reg == RUN) && !halt_det;
   assign cyc_cnt_next = sat_add(cyc_cnt_reg, 2'd1);
   assign ins_cnt_next = sat_add(ins_cnt_reg, ins_inc);
   assign timeout_hit  = (wide_t'(cyc_cnt_next) == MAX_W);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= RUN;
      else       state_reg <= state_next;
   end

   // Next state: clear wins, then halt over timeout; end states are sticky.
   always_comb begin
      state_next = state_reg;
      if (bus.clear_i) begin
         state_next = RUN;
      end else begin
         case (state_reg)
            RUN: begin
               if (halt_det)         state_next = HALTED;
               else if (timeout_hit) state_next = TIMEOUT;
            end
            default: ;
         endcase
      end
   end

   // Main counters, previous-PC tracking and halt PC capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_cnt_reg  <= '0;
         ins_cnt_reg  <= '0;
         prev_pc1_reg <= '0;
         prev_pc2_reg <= '0;
         prev_vld_reg <= 1'b0;
         halt_pc_reg  <= '0;
      end else if (bus.clear_i) begin
         cyc_cnt_reg  <= '0;
         ins_cnt_reg  <= '0;
         prev_pc1_reg <= '0;
         prev_pc2_reg <= '0;
         prev_vld_reg <= 1'b0;
         halt_pc_reg  <= '0;
      end else if (state_reg == RUN) begin
         if (halt_det) begin
            halt_pc_reg <= bus.PCF_i;
         end else begin
            cyc_cnt_reg  <= cyc_cnt_next;
            ins_cnt_reg  <= ins_cnt_next;
            prev_pc1_reg <= bus.PCF_i;
            prev_pc2_reg <= bus.PCF2_i;
            prev_vld_reg <= 1'b1;
         end
      end
   end

`ifdef PERFMON_LANE_STATS_EN
   logic [CNT_W-1:0] dual_cnt_reg, stall_cnt_reg;

   // Dual-issue and decode-stall counters, same clear/freeze rules as above.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dual_cnt_reg  <= '0;
         stall_cnt_reg <= '0;
      end else if (bus.clear_i) begin
         dual_cnt_reg  <= '0;
         stall_cnt_reg <= '0;
      end else if (cnt_en) begin
         if (&lane_vld)    dual_cnt_reg  <= sat_add(dual_cnt_reg, 2'd1);
         if (bus.StallD_i) stall_cnt_reg <= sat_add(stall_cnt_reg, 2'd1);
      end
   end
`endif

   // Read mux over pre-update register values.
   always_comb begin
      rd_data_next = 32'd0;
      case (bus.rd_addr_i)
         3'd0: rd_data_next = 32'(cyc_cnt_reg);
         3'd1: rd_data_next = 32'(ins_cnt_reg);
         3'd2: rd_data_next = {29'd0, state_reg == TIMEOUT, state_reg == HALTED,
                               state_reg == RUN};
         3'd3: rd_data_next = halt_pc_reg;
`ifdef PERFMON_LANE_STATS_EN
         3'd4: rd_data_next = 32'(dual_cnt_reg);
         3'd5: rd_data_next = 32'(stall_cnt_reg);
`endif
         default: rd_data_next = 32'd0;
      endcase
   end

   // Registered read response: one-cycle latency, ack follows the request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ack_reg  <= 1'b0;
         rd_data_reg <= '0;
      end else begin
         rd_ack_reg <= bus.rd_req_i;
         if (bus.rd_req_i) rd_data_reg <= rd_data_next;
      end
   end

   assign bus.rd_ack_o  = rd_ack_reg;
   assign bus.rd_data_o = rd_data_reg;
   assign bus.halted_o  = (state_reg == HALTED);
   assign bus.timeout_o = (state_reg == TIMEOUT);

endmodule

// File: tb/tb_ucsbece154b_perfmon.sv
// Self-checking bench for ucsbece154b_perfmon: table-driven read vectors plus
// hand-written halt/timeout/clear/saturation sequences; read results are
// checked through a scoreboard queue. A second instance uses CNT_W = 4.
module tb_ucsbece154b_perfmon;

   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] V1  = 32'h00100093;
   localparam logic [31:0] V2  = 32'h00500293;
`ifdef PERFMON_LANE_STATS_EN
   localparam bit LS = 1'b1;
`else
   localparam bit LS = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic reset4;
   always #5 clk = ~clk;

   ucsbece154b_perfmon_if bus();
   ucsbece154b_perfmon_if bus4();

   ucsbece154b_perfmon dut (.clk(clk), .reset(reset), .bus(bus));
   ucsbece154b_perfmon #(.CNT_W(4)) dut4 (.clk(clk), .reset(reset4), .bus(bus4));

   int total = 0;
   int bad   = 0;
   logic [31:0] pc;

   logic [31:0] sb_exp[$];
   string       sb_nm[$];
   logic        req_seen  = 1'b0;
   logic        req4_seen = 1'b0;

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      logic        st;
      logic [2:0]  addr;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Ack must follow the request sampled at the previous edge; data is popped
   // from the scoreboard whenever a response is due.
   task automatic mon(input logic ack, input logic [31:0] data, input logic req,
                      input string tag);
      string       n;
      logic [31:0] e;
      chk(tag, 32'(ack), 32'(req));
      if (req) begin
         if (sb_exp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: response 0x%08h with empty scoreboard", tag, data);
         end else begin
            n = sb_nm.pop_front();
            e = sb_exp.pop_front();
            $display("read %s: data=0x%08h exp=0x%08h", n, data, e);
            chk(n, data, e);
         end
      end
   endtask

   always @(posedge clk) begin
      req_seen  <= bus.rd_req_i && !reset;
      req4_seen <= bus4.rd_req_i && !reset4;
   end

   always @(negedge clk) begin
      mon(bus.rd_ack_o, bus.rd_data_o, req_seen, "ack");
      mon(bus4.rd_ack_o, bus4.rd_data_o, req4_seen, "ack4");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // Advance both fetch PCs each cycle (fetch instr stays non-NOP, no halt).
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         bus.PCF_i  = pc;
         bus.PCF2_i = pc + 32'd4;
         pc         = pc + 32'd8;
         tick();
      end
   endtask

   task automatic rd(input int inst, input logic [2:0] a, input logic [31:0] e,
                     input string nm);
      if (inst == 0) begin
         bus.rd_req_i  = 1'b1;
         bus.rd_addr_i = a;
      end else begin
         bus4.rd_req_i  = 1'b1;
         bus4.rd_addr_i = a;
      end
      sb_exp.push_back(e);
      sb_nm.push_back(nm);
      tick();
      bus.rd_req_i  = 1'b0;
      bus4.rd_req_i = 1'b0;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      reset4 = 1'b1;
      bus.PCF_i = '0;  bus.InstrF_i = '0;  bus.PCF2_i = '0;  bus.InstrF2_i = '0;
      bus.InstrD_i = '0; bus.InstrD2_i = '0; bus.StallD_i = 0; bus.clear_i = 0;
      bus.rd_req_i = 0; bus.rd_addr_i = '0;
      bus4.PCF_i = '0; bus4.InstrF_i = '0; bus4.PCF2_i = '0; bus4.InstrF2_i = '0;
      bus4.InstrD_i = '0; bus4.InstrD2_i = '0; bus4.StallD_i = 0; bus4.clear_i = 0;
      bus4.rd_req_i = 0; bus4.rd_addr_i = '0;
      pc = 32'h1000;
      tick();
      tick();
      reset  = 1'b0;
      reset4 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Rows: decode lanes, stall, read address, expected read (pre-edge value).
      vecs[0]  = '{V1, NOP, 1'b0, 3'd1, 32'd0};
      vecs[1]  = '{V1, NOP, 1'b0, 3'd1, 32'd1};
      vecs[2]  = '{V1, NOP, 1'b0, 3'd1, 32'd2};
      vecs[3]  = '{V1, NOP, 1'b0, 3'd1, 32'd3};
      vecs[4]  = '{V1, NOP, 1'b0, 3'd1, 32'd4};
      vecs[5]  = '{V1, V2,  1'b1, 3'd1, 32'd5};
      vecs[6]  = '{V1, V2,  1'b1, 3'd5, LS ? 32'd1 : 32'd0};
      vecs[7]  = '{V1, V2,  1'b1, 3'd4, 32'd0};
      vecs[8]  = '{32'd0, 32'd0, 1'b0, 3'd1, 32'd5};
      vecs[9]  = '{32'd0, 32'd0, 1'b0, 3'd5, LS ? 32'd3 : 32'd0};
      vecs[10] = '{32'd0, 32'd0, 1'b0, 3'd4, 32'd0};
      vecs[11] = '{32'd0, 32'd0, 1'b0, 3'd0, 32'd11};
      vecs[12] = '{32'd0, 32'd0, 1'b0, 3'd6, 32'd0};
      vecs[13] = '{32'd0, 32'd0, 1'b0, 3'd7, 32'd0};
      vecs[14] = '{32'd0, 32'd0, 1'b0, 3'd2, 32'd1};
      vecs[15] = '{V1, V2,  1'b0, 3'd4, 32'd0};
      vecs[16] = '{32'd0, 32'd0, 1'b0, 3'd4, LS ? 32'd1 : 32'd0};
      vecs[17] = '{32'd0, 32'd0, 1'b0, 3'd1, 32'd7};

      // Reset values observed through the read port.
      do_reset();
      chk("rst_halted", 32'(bus.halted_o), 32'd0);
      chk("rst_timeout", 32'(bus.timeout_o), 32'd0);
      rd(0, 3'd0, 32'd0, "rst_cyc");
      rd(0, 3'd1, 32'd0, "rst_ins");
      rd(0, 3'd2, 32'd1, "rst_status");
      rd(0, 3'd3, 32'd0, "rst_halt_pc");

      // Halt after 10 dual-valid cycles and one repeated NOP fetch.
      do_reset();
      bus.InstrD_i  = V1;
      bus.InstrD2_i = V2;
      run(10);
      bus.InstrD_i  = NOP;
      bus.InstrD2_i = NOP;
      bus.PCF_i     = 32'h40;
      bus.PCF2_i    = 32'h44;
      bus.InstrF_i  = NOP;
      bus.InstrF2_i = NOP;
      tick();
      chk("A_not_yet_halted", 32'(bus.halted_o), 32'd0);
      tick();
      chk("A_halted", 32'(bus.halted_o), 32'd1);
      chk("A_no_timeout", 32'(bus.timeout_o), 32'd0);
      rd(0, 3'd0, 32'd11, "A_cyc");
      rd(0, 3'd1, 32'd20, "A_ins");
      rd(0, 3'd2, 32'd2, "A_status");
      rd(0, 3'd3, 32'h40, "A_halt_pc");
      repeat (3) tick();
      rd(0, 3'd0, 32'd11, "A_freeze");
      bus.clear_i = 1'b1;
      tick();
      bus.clear_i = 1'b0;
      chk("A_clear_run", 32'(bus.halted_o), 32'd0);
      rd(0, 3'd2, 32'd1, "A_clr_status");
      tick();
      chk("A_rehalt", 32'(bus.halted_o), 32'd1);
      rd(0, 3'd0, 32'd1, "A_rehalt_cyc");
      // Asynchronous reset mid-cycle.
      #2 reset = 1'b1;
      #1;
      chk("async_rst_halted", 32'(bus.halted_o), 32'd0);
      chk("async_rst_ack", 32'(bus.rd_ack_o), 32'd0);
      chk("async_rst_data", bus.rd_data_o, 32'd0);

      // Vector table: per-lane valid, stall, stats counters and read map.
      do_reset();
      for (int i = 0; i < 18; i++) begin
         bus.InstrD_i  = vecs[i].d1;
         bus.InstrD2_i = vecs[i].d2;
         bus.StallD_i  = vecs[i].st;
         rd(0, vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
      end
      bus.StallD_i = 1'b0;

      // Timeout on the edge the cycle count reaches the budget.
      do_reset();
      run(199);
      chk("C_pre_timeout", 32'(bus.timeout_o), 32'd0);
      run(1);
      chk("C_timeout", 32'(bus.timeout_o), 32'd1);
      chk("C_not_halted", 32'(bus.halted_o), 32'd0);
      run(3);
      rd(0, 3'd0, 32'd200, "C_cyc_frozen");
      rd(0, 3'd2, 32'd4, "C_status");

      // Halt condition present on the first edge after reset release.
      do_reset();
      bus.InstrF_i  = NOP;
      bus.InstrF2_i = NOP;
      tick();
      chk("D_first_edge", 32'(bus.halted_o), 32'd0);
      tick();
      chk("D_halted", 32'(bus.halted_o), 32'd1);
      rd(0, 3'd0, 32'd1, "D_cyc");
      rd(0, 3'd3, 32'd0, "D_halt_pc");

      // Read and clear on the same edge.
      do_reset();
      run(9);
      bus.clear_i = 1'b1;
      rd(0, 3'd0, 32'd9, "E_rd_with_clr");
      bus.clear_i = 1'b0;
      rd(0, 3'd0, 32'd0, "E_post_clr");
      rd(0, 3'd0, 32'd1, "E_post_clr2");

      // CNT_W = 4 saturation; budget of 200 is unreachable for this width.
      do_reset();
      bus4.InstrD_i  = V1;
      bus4.InstrD2_i = V2;
      repeat (7) tick();
      rd(1, 3'd1, 32'd14, "F_ins14");
      rd(1, 3'd1, 32'd15, "F_ins_sat");
      bus4.InstrD_i  = '0;
      bus4.InstrD2_i = '0;
      rd(1, 3'd1, 32'd15, "F_ins_hold");
      repeat (10) tick();
      rd(1, 3'd0, 32'd15, "F_cyc_sat");
      rd(1, 3'd2, 32'd1, "F_status");

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
